// File: rtl/phoenix_memory_arbiter_pkg.sv
// Shared encodings for the phoenix memory arbiter: core access encodings,
// arbiter state encoding and requester grant IDs.
`default_nettype none

package phoenix_memory_arbiter_pkg;

  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [3:0] FULL_WORD_MASK = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

  function automatic grant_t other_grant(input grant_t g);
    return (g == INSTR) ? DATA : INSTR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phoenix_memory_arbiter_if.sv
// Bus bundle for the phoenix memory arbiter: fetch port, data port, memory port
// and console strobe. slave = arbiter view, master = core/memory environment view.
`default_nettype none

interface phoenix_memory_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic                     instr_enable;
  logic [ADDRESS_WIDTH-1:0] instr_address;
  logic [DATA_WIDTH-1:0]    instr_data;
  logic                     instr_done;

  logic                     data_enable;
  logic                     data_state;
  logic [ADDRESS_WIDTH-1:0] data_address;
  logic [3:0]               data_frame_mask;
  logic [DATA_WIDTH-1:0]    data_wdata;
  logic [DATA_WIDTH-1:0]    data_rdata;
  logic                     data_done;
  logic                     bus_error;

  logic                     mem_req;
  logic                     mem_write;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [3:0]               mem_frame_mask;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     mem_ack;

  logic                     console_valid;
  logic [7:0]               console_char;

  modport slave (
    input  instr_enable, instr_address,
    output instr_data, instr_done,
    input  data_enable, data_state, data_address, data_frame_mask, data_wdata,
    output data_rdata, data_done, bus_error,
    output mem_req, mem_write, mem_address, mem_frame_mask, mem_wdata,
    input  mem_rdata, mem_ack,
    output console_valid, console_char
  );

  modport master (
    output instr_enable, instr_address,
    input  instr_data, instr_done,
    output data_enable, data_state, data_address, data_frame_mask, data_wdata,
    input  data_rdata, data_done, bus_error,
    input  mem_req, mem_write, mem_address, mem_frame_mask, mem_wdata,
    output mem_rdata, mem_ack,
    input  console_valid, console_char
  );

endinterface

`default_nettype wire

// File: rtl/phoenix_memory_arbiter_rr_grant.sv
// phoenix_rr_grant: combinational 2-way round-robin picker. Under contention the
// requester that did not win last time is chosen; the arbiter holds last_grant.
`default_nettype none

module phoenix_rr_grant
  import phoenix_memory_arbiter_pkg::*;
(
  input  logic   i_req_instr,
  input  logic   i_req_data,
  input  grant_t i_last_grant,
  output logic   o_grant_valid,
  output grant_t o_grant_id
);

  always_comb begin
    o_grant_valid = (i_req_instr == ENABLE) || (i_req_data == ENABLE);
    o_grant_id    = INSTR;
    if ((i_req_instr == ENABLE) && (i_req_data == ENABLE)) begin
      o_grant_id = other_grant(i_last_grant);
    end else if (i_req_data == ENABLE) begin
      o_grant_id = DATA;
    end
  end

endmodule

`default_nettype wire

// File: rtl/phoenix_memory_arbiter.sv
// phoenix_memory_arbiter: serialises fetch and data accesses onto one ready/ack
// memory port with round-robin choice and timeout. Optional: PHOENIX_ARBITER_CONSOLE_EN.
`default_nettype none

module phoenix_memory_arbiter
  import phoenix_memory_arbiter_pkg::*;
#(
  parameter int          ADDRESS_WIDTH   = 32,
  parameter int          DATA_WIDTH      = 32,
  parameter int          TIMEOUT_CYCLES  = 255,
  parameter logic [31:0] CONSOLE_ADDRESS = 32'h1000_0000
) (
  input logic                     clk,
  input logic                     reset,
  phoenix_memory_arbiter_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  grant_t                   r_last_grant;
  grant_t                   r_winner;
  logic [CNT_W-1:0]         r_count;

  logic                     r_mem_req;
  logic                     r_mem_write;
  logic [ADDRESS_WIDTH-1:0] r_mem_address;
  logic [3:0]               r_mem_frame_mask;
  logic [DATA_WIDTH-1:0]    r_mem_wdata;
  logic [DATA_WIDTH-1:0]    r_instr_data;
  logic                     r_instr_done;
  logic [DATA_WIDTH-1:0]    r_data_rdata;
  logic                     r_data_done;
  logic                     r_bus_error;

  logic                     w_grant_valid;
  grant_t                   w_grant_id;
  logic                     w_console_hit;
  logic                     w_load;
  logic                     w_bypass;
  logic                     w_ack;
  logic                     w_timeout;

  phoenix_rr_grant u_rr_grant (
    .i_req_instr   (bus.instr_enable),
    .i_req_data    (bus.data_enable),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

`ifdef PHOENIX_ARBITER_CONSOLE_EN
  logic       r_console_valid;
  logic [7:0] r_console_char;

  assign w_console_hit = (w_grant_id == DATA) &&
                         (bus.data_address == ADDRESS_WIDTH'(CONSOLE_ADDRESS));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_console_valid <= 1'b0;
      r_console_char  <= 8'h00;
    end else if (w_bypass && (bus.data_state == WRITE)) begin
      r_console_valid <= 1'b1;
      r_console_char  <= bus.data_wdata[7:0];
    end else begin
      r_console_valid <= 1'b0;
      r_console_char  <= 8'h00;
    end
  end

  assign bus.console_valid = r_console_valid;
  assign bus.console_char  = r_console_char;
`else
  logic w_unused_console;

  assign w_console_hit     = 1'b0;
  assign w_unused_console  = ^CONSOLE_ADDRESS;
  assign bus.console_valid = 1'b0;
  assign bus.console_char  = 8'h00;
`endif

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_bypass     = 1'b0;
    w_ack        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_load = 1'b1;
          if (w_console_hit) begin
            w_bypass     = 1'b1;
            w_state_next = RESP;
          end else begin
            w_state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        // An ack on the final counted cycle still beats the timeout.
        if (bus.mem_ack) begin
          w_ack        = 1'b1;
          w_state_next = RESP;
        end else if (r_count == c_timeout_last) begin
          w_timeout    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_last_grant     <= DATA;
      r_winner         <= INSTR;
      r_count          <= '0;
      r_mem_req        <= DISABLE;
      r_mem_write      <= READ;
      r_mem_address    <= '0;
      r_mem_frame_mask <= 4'b0000;
      r_mem_wdata      <= '0;
      r_instr_data     <= '0;
      r_instr_done     <= 1'b0;
      r_data_rdata     <= '0;
      r_data_done      <= 1'b0;
      r_bus_error      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_instr_done <= 1'b0;
      r_data_done  <= 1'b0;
      r_bus_error  <= 1'b0;

      if (r_state == ISSUE) begin
        r_count <= r_count + 1'b1;
      end

      if (w_load) begin
        r_last_grant <= w_grant_id;
        r_winner     <= w_grant_id;
        r_count      <= '0;
        r_mem_req    <= w_bypass ? DISABLE : ENABLE;
        if (w_grant_id == INSTR) begin
          r_mem_write      <= READ;
          r_mem_address    <= bus.instr_address;
          r_mem_frame_mask <= FULL_WORD_MASK;
          r_mem_wdata      <= '0;
        end else begin
          r_mem_write      <= bus.data_state;
          r_mem_address    <= bus.data_address;
          r_mem_frame_mask <= bus.data_frame_mask;
          r_mem_wdata      <= bus.data_wdata;
        end
        if (w_bypass) begin
          r_data_done  <= 1'b1;
          r_data_rdata <= '0;
        end
      end

      if (w_ack || w_timeout) begin
        r_mem_req   <= DISABLE;
        r_bus_error <= w_timeout;
        if (r_winner == INSTR) begin
          r_instr_done <= 1'b1;
          r_instr_data <= w_ack ? bus.mem_rdata : '0;
        end else begin
          r_data_done  <= 1'b1;
          r_data_rdata <= (w_ack && (r_mem_write == READ)) ? bus.mem_rdata : '0;
        end
      end
    end
  end

  assign bus.mem_req        = r_mem_req;
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_frame_mask = r_mem_frame_mask;
  assign bus.mem_wdata      = r_mem_wdata;
  assign bus.instr_data     = r_instr_data;
  assign bus.instr_done     = r_instr_done;
  assign bus.data_rdata     = r_data_rdata;
  assign bus.data_done      = r_data_done;
  assign bus.bus_error      = r_bus_error;

endmodule

`default_nettype wire

// File: tb/tb_phoenix_memory_arbiter.sv
// Directed self-checking bench for phoenix_memory_arbiter (TIMEOUT_CYCLES=8),
// with a wait-state-programmable memory model driving the ready/ack port.
`default_nettype none

module tb_phoenix_memory_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  int          mem_wait = 0;
  bit          mem_hang = 0;
  int          mem_waited = 0;
  int          mem_req_cycles = 0;
  bit          mem_req_seen = 0;
  logic [3:0]  cap_mask;
  logic        cap_write;
  logic [31:0] cap_wdata;
  logic [31:0] cap_addr;

  phoenix_memory_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  phoenix_memory_arbiter #(
    .ADDRESS_WIDTH   (32),
    .DATA_WIDTH      (32),
    .TIMEOUT_CYCLES  (8),
    .CONSOLE_ADDRESS (32'h1000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: ack after mem_wait cycles of mem_req, data derived from address.
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      mem_req_seen = 1'b1;
      mem_req_cycles++;
      if (!mem_hang && mem_waited == mem_wait) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = (bus.mem_address == 32'h100) ? 32'h0000_0013
                                                     : (bus.mem_address ^ 32'hDEAD_0000);
        cap_mask  = bus.mem_frame_mask;
        cap_write = bus.mem_write;
        cap_wdata = bus.mem_wdata;
        cap_addr  = bus.mem_address;
      end else begin
        bus.mem_ack = 1'b0;
      end
      mem_waited++;
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      mem_waited    = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "global timeout");
  end

  task automatic wait_done(input bit is_data, input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget && lat < 0; c++) begin
      @(posedge clk); #1;
      if ((is_data ? bus.data_done : bus.instr_done) === 1'b1) lat = c;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.instr_enable = 1'b0; bus.instr_address = 32'h0;
    bus.data_enable = 1'b0; bus.data_state = 1'b0; bus.data_address = 32'h0;
    bus.data_frame_mask = 4'b0; bus.data_wdata = 32'h0;
    mem_wait = 0; mem_hang = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.instr_done, bus.data_done, bus.bus_error, bus.mem_req, bus.mem_write} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00000",
        {bus.instr_done, bus.data_done, bus.bus_error, bus.mem_req, bus.mem_write});
    end
    n_checks++;
    if ({bus.instr_data, bus.data_rdata, bus.mem_address, bus.mem_wdata} !== 128'h0) begin
      n_fail++; $display("FAIL reset_buses: got %h %h %h %h expected all 0",
        bus.instr_data, bus.data_rdata, bus.mem_address, bus.mem_wdata);
    end
    n_checks++;
    if ({bus.mem_frame_mask, bus.console_valid, bus.console_char} !== 13'h0) begin
      n_fail++; $display("FAIL reset_mask_console: got %h %b %h expected 0 0 0",
        bus.mem_frame_mask, bus.console_valid, bus.console_char);
    end
  endtask

  task automatic test_fetch_alone();
    int lat;
    @(posedge clk); #1;
    bus.instr_address = 32'h100; bus.instr_enable = 1'b1;
    wait_done(1'b0, 20, lat);
    bus.instr_enable = 1'b0;
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 2", lat); end
    n_checks++;
    if (bus.instr_data !== 32'h0000_0013) begin
      n_fail++; $display("FAIL fetch_data: got %h expected 00000013", bus.instr_data);
    end
    n_checks++;
    if (bus.bus_error !== 1'b0 || bus.data_done !== 1'b0) begin
      n_fail++; $display("FAIL fetch_flags: got err=%b ddone=%b expected 0 0", bus.bus_error, bus.data_done);
    end
    n_checks++;
    if (cap_mask !== 4'b1111 || cap_write !== 1'b0) begin
      n_fail++; $display("FAIL fetch_mem_port: got mask=%b write=%b expected 1111 0", cap_mask, cap_write);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.instr_done !== 1'b0) begin
      n_fail++; $display("FAIL fetch_done_width: got %b expected 0", bus.instr_done);
    end
  endtask

  task automatic test_contention();
    int t_i1 = -1, t_d = -1, t_i2 = -1;
    logic [31:0] v_i1 = '0, v_d = '0, v_i2 = '0;
    do_reset();
    @(posedge clk); #1;
    bus.instr_address = 32'h0; bus.instr_enable = 1'b1;
    bus.data_address = 32'h2000; bus.data_state = 1'b0;
    bus.data_frame_mask = 4'b1111; bus.data_enable = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.instr_done === 1'b1) begin
        if (t_i1 < 0) begin
          t_i1 = c; v_i1 = bus.instr_data; bus.instr_address = 32'h4;
        end else begin
          t_i2 = c; v_i2 = bus.instr_data; bus.instr_enable = 1'b0;
        end
      end
      if (bus.data_done === 1'b1) begin
        t_d = c; v_d = bus.data_rdata; bus.data_enable = 1'b0;
      end
    end
    bus.instr_enable = 1'b0; bus.data_enable = 1'b0;
    n_checks++;
    if (t_i1 !== 2 || t_d !== 5 || t_i2 !== 8) begin
      n_fail++; $display("FAIL contention_order: got instr=%0d data=%0d instr=%0d expected 2 5 8", t_i1, t_d, t_i2);
    end
    n_checks++;
    if (v_i1 !== 32'hDEAD_0000 || v_d !== 32'hDEAD_2000 || v_i2 !== 32'hDEAD_0004) begin
      n_fail++; $display("FAIL contention_data: got %h %h %h expected dead0000 dead2000 dead0004", v_i1, v_d, v_i2);
    end
  endtask

  task automatic test_write_wait();
    int lat;
    @(posedge clk); #1;
    mem_wait = 3;
    bus.data_address = 32'h40; bus.data_state = 1'b1; bus.data_frame_mask = 4'b0001;
    bus.data_wdata = 32'hAABB_CCDD; bus.data_enable = 1'b1;
    wait_done(1'b1, 20, lat);
    bus.data_enable = 1'b0;
    mem_wait = 0;
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL write_latency: got %0d expected 5", lat); end
    n_checks++;
    if (bus.data_rdata !== 32'h0 || bus.bus_error !== 1'b0) begin
      n_fail++; $display("FAIL write_rdata: got %h err=%b expected 0 0", bus.data_rdata, bus.bus_error);
    end
    n_checks++;
    if (cap_mask !== 4'b0001 || cap_write !== 1'b1 || cap_wdata !== 32'hAABB_CCDD || cap_addr !== 32'h40) begin
      n_fail++; $display("FAIL write_mem_port: got mask=%b w=%b d=%h a=%h expected 0001 1 aabbccdd 40",
        cap_mask, cap_write, cap_wdata, cap_addr);
    end
  endtask

  task automatic test_timeout();
    int lat;
    @(posedge clk); #1;
    mem_hang = 1'b1; mem_req_cycles = 0;
    bus.data_address = 32'h80; bus.data_state = 1'b0; bus.data_frame_mask = 4'b1111;
    bus.data_enable = 1'b1;
    wait_done(1'b1, 30, lat);
    bus.data_enable = 1'b0;
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 9", lat); end
    n_checks++;
    if (bus.bus_error !== 1'b1 || bus.data_rdata !== 32'h0) begin
      n_fail++; $display("FAIL timeout_error: got err=%b rdata=%h expected 1 0", bus.bus_error, bus.data_rdata);
    end
    n_checks++;
    if (mem_req_cycles !== 8 || bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_req_cycles: got %0d req=%b expected 8 0", mem_req_cycles, bus.mem_req);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.bus_error !== 1'b0 || bus.data_done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse_width: got err=%b done=%b expected 0 0", bus.bus_error, bus.data_done);
    end
    mem_hang = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    int lat;
    int dones = 0;
    @(posedge clk); #1;
    mem_hang = 1'b1;
    bus.instr_address = 32'h200; bus.instr_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL midissue_req_before: got %b expected 1", bus.mem_req); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.instr_done !== 1'b0) begin
      n_fail++; $display("FAIL midissue_reset: got req=%b done=%b expected 0 0", bus.mem_req, bus.instr_done);
    end
    bus.instr_enable = 1'b0;
    reset = 1'b0; mem_hang = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.instr_done === 1'b1 || bus.mem_req === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL midissue_abandoned: got %0d activity cycles expected 0", dones); end
    bus.instr_address = 32'h100; bus.instr_enable = 1'b1;
    wait_done(1'b0, 20, lat);
    bus.instr_enable = 1'b0;
    n_checks++;
    if (lat !== 2 || bus.instr_data !== 32'h0000_0013) begin
      n_fail++; $display("FAIL midissue_followup: got lat=%0d data=%h expected 2 00000013", lat, bus.instr_data);
    end
  endtask

`ifdef PHOENIX_ARBITER_CONSOLE_EN
  task automatic test_console();
    int lat;
    @(posedge clk); #1;
    mem_req_seen = 1'b0;
    bus.data_address = 32'h1000_0000; bus.data_state = 1'b1; bus.data_frame_mask = 4'b1111;
    bus.data_wdata = 32'h0000_0041; bus.data_enable = 1'b1;
    wait_done(1'b1, 20, lat);
    bus.data_enable = 1'b0;
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL console_latency: got %0d expected 1", lat); end
    n_checks++;
    if (bus.console_valid !== 1'b1 || bus.console_char !== 8'h41) begin
      n_fail++; $display("FAIL console_strobe: got v=%b c=%h expected 1 41", bus.console_valid, bus.console_char);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.console_valid !== 1'b0 || mem_req_seen !== 1'b0) begin
      n_fail++; $display("FAIL console_bypass: got v=%b req_seen=%b expected 0 0", bus.console_valid, mem_req_seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_alone();
    test_contention();
    test_write_wait();
    test_timeout();
    test_reset_mid_issue();
`ifdef PHOENIX_ARBITER_CONSOLE_EN
    test_console();
`endif
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/phoenix_memory_arbiter.md
Name: phoenix_memory_arbiter

Overview:
- Shares one single-port system memory between the core's instruction fetch interface and data memory interface.
- Serialises requests, picks between them with 2-way round-robin, and drives a ready/ack memory port that can take any number of wait states.
- Returns a one-cycle done pulse with read data to whichever requester won.
- Sits between the core and the memory/peripheral fabric. Replaces the ad-hoc shared-memory behaviour in simulation.

Parameters:
- ADDRESS_WIDTH, 32, width of address buses.
- DATA_WIDTH, 32, width of data buses.
- TIMEOUT_CYCLES, 255, maximum cycles in ISSUE waiting for mem_ack before the access is aborted with an error.
- CONSOLE_ADDRESS, 32'h1000_0000, MMIO console byte address (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- instr_enable  in  1  instruction fetch request
- instr_address  in  ADDRESS_WIDTH  fetch address, word aligned
- instr_data  out  DATA_WIDTH  fetched word, valid while instr_done=1
- instr_done  out  1  one-cycle completion pulse
- data_enable  in  1  data access request
- data_state  in  1  0=READ, 1=WRITE (core encoding)
- data_address  in  ADDRESS_WIDTH  data address
- data_frame_mask  in  4  byte enables; bit3 is byte[7:0], bit0 is byte[31:24]
- data_wdata  in  DATA_WIDTH  store data
- data_rdata  out  DATA_WIDTH  load data, valid while data_done=1
- data_done  out  1  one-cycle completion pulse
- bus_error  out  1  pulses with a done pulse when that access timed out
- mem_req  out  1  memory request, held until ack
- mem_write  out  1  1=write
- mem_address  out  ADDRESS_WIDTH
- mem_frame_mask  out  4  passed through unchanged; 4'b1111 for fetches
- mem_wdata  out  DATA_WIDTH
- mem_rdata  in  DATA_WIDTH  sampled on the edge where mem_ack=1
- mem_ack  in  1  completion from memory; may be asserted in the first cycle of mem_req
- console_valid  out  1  console byte strobe (optional feature)
- console_char  out  8  console byte (optional feature)

Behaviour:
- Clocking and reset: all outputs are registered. Reset is synchronous and active-high.
- Reset values: every output is 0; state=IDLE; last_grant=DATA, so the first contested grant goes to instruction.
- Requester contract: a requester holds enable, address, state, mask and wdata stable from assertion until the cycle it sees done. It may re-request in the cycle after done. Enable dropped before done is a protocol violation; the access completes anyway.

State IDLE:
- No request: stay in IDLE.
- Only one requester: grant it.
- Both requesters: grant the one not equal to last_grant.
- On grant: register address, mask, wdata and the write flag onto the mem_* outputs; update last_grant; go to ISSUE.

State ISSUE:
- mem_req=1 and the timeout counter increments.
- mem_ack at a clock edge: capture mem_rdata into the winner's rdata register, clear mem_req, go to RESP.
- Counter reaching TIMEOUT_CYCLES: clear mem_req, set rdata=0, raise bus_error for RESP, go to RESP.
- mem_ack in the same cycle as the timeout: ack wins, no error.

State RESP:
- Winner's done=1 for exactly one cycle (bus_error alongside if set); return to IDLE.
- Other requester: its enable stays pending; it is granted in the next IDLE cycle.

Latency and throughput:
- Request first seen in cycle N with zero-wait memory (ack in N+1): done in N+2.
- Each memory wait state adds one cycle.
- Back-to-back throughput: one access per 3 cycles.
- Fetch-versus-data starvation is impossible: strict alternation under contention.

Writes:
- A write completes with data_done; data_rdata=0.
- Reset in any state: return to IDLE, drop mem_req immediately, emit no done pulse; the in-flight access is abandoned.

Optional Feature:
- Macro: PHOENIX_ARBITER_CONSOLE_EN.
- Defined: a granted data WRITE to CONSOLE_ADDRESS never reaches memory; mem_req stays 0. The access goes IDLE to RESP directly, so done arrives in N+1. console_valid pulses in the RESP cycle with console_char = data_wdata[7:0]. A read from CONSOLE_ADDRESS returns 0 and also bypasses memory.
- Undefined: console_valid and console_char are tied 0; CONSOLE_ADDRESS is an ordinary memory address.

Decomposition:
- Shared defines header, existing one: READ/WRITE and ENABLE/DISABLE encodings. Add the state encoding localparams IDLE, ISSUE, RESP and the grant IDs INSTR, DATA.
- Sub-module: phoenix_rr_grant, a 2-way round-robin picker (inputs: two requests, last_grant; outputs: grant valid, grant ID). Keep it combinational, with last_grant held in the arbiter.

Test Plan:
1. Fetch alone: instr_address=0x100, memory returns 0x00000013 with zero wait. Expect instr_done exactly 2 cycles after request, instr_data=0x00000013, bus_error=0.
2. Simultaneous requests right after reset: instr@0x0 plus data READ@0x2000. Expect fetch served first, then data; the next contested pair serves data first.
3. Data WRITE@0x40, mask 4'b0001, wdata=0xAABBCCDD, memory with 3 wait states. Expect mem_frame_mask=4'b0001, data_done 5 cycles after request, data_rdata=0.
4. No mem_ack with TIMEOUT_CYCLES=8. Expect mem_req dropped after 8 cycles, data_done and bus_error pulsing together, data_rdata=0.
5. Reset asserted mid-ISSUE. Expect next edge mem_req=0, no done pulse, state IDLE; a following fetch completes normally.
6. Console feature on: data WRITE@0x1000_0000, wdata=0x41. Expect console_valid one cycle with console_char=8'h41, mem_req never asserted, data_done 1 cycle after request.
